// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: encodes field-stream instructions into 16-bit
// words, buffers them in a 4-entry FIFO and writes them to instruction memory
// starting at a session base address.

package instr_encoder_loader_pkg;
  typedef enum logic [2:0] {
    OP_R_TYPE = 3'd0,
    OP_SHIFT  = 3'd1,
    OP_LI     = 3'd2,
    OP_LW     = 3'd3,
    OP_SW     = 3'd4,
    OP_BNEZ   = 3'd5,
    OP_J      = 3'd6,
    OP_JAL    = 3'd7
  } opcode_t;
endpackage

module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        finish,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs1,
  input  logic [2:0]  in_rs2,
  input  logic [3:0]  in_funct,
  input  logic [15:0] in_imm,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [8:0]  count,
  output logic        err_range,
  output logic        err_full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] fifo_q [4];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  occ_q;
  logic [7:0]  addr_q;
  logic [8:0]  count_q;
  logic        err_range_q;
  logic        err_full_q;

  logic [15:0]        enc_word;
  logic               enc_legal;
  logic signed [15:0] imm_s;
  logic               accept;
  logic               push;
  logic               pop;
  logic               flush;
  logic               session_start;

  assign imm_s = $signed(in_imm);

  // Encode the incoming fields and judge whether the immediate fits its slot.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (opcode_t'(in_op))
      OP_R_TYPE, OP_SHIFT: begin
        enc_word = {in_op, in_rd, in_rs1, in_rs2, in_funct};
      end
      OP_LI, OP_LW, OP_SW: begin
        enc_word  = {in_op, in_rd, in_rs1, in_imm[6:0]};
        enc_legal = (imm_s >= -16'sd64) && (imm_s <= 16'sd63);
      end
      OP_BNEZ: begin
        enc_word  = {in_op, in_rs1, in_imm[9:0]};
        enc_legal = (imm_s >= -16'sd512) && (imm_s <= 16'sd511);
      end
      OP_J, OP_JAL: begin
        // Jump targets are unsigned: only the top three bits must be clear.
        enc_word  = {in_op, in_imm[12:0]};
        enc_legal = (in_imm[15:13] == 3'b000);
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign in_ready      = (state_q == S_LOAD) && (occ_q != 3'd4) && !err_full_q;
  assign accept        = in_valid && in_ready;
  assign push          = accept && enc_legal;
  assign mem_we        = (occ_q != 3'd0);
  assign pop           = mem_we && mem_ack;
  // Acknowledging the last address exhausts the space and drops what is queued.
  assign flush         = pop && (addr_q == 8'hFF);
  assign session_start = (state_q == S_IDLE) && start;

  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : '0;
  assign busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign count     = count_q;
  assign err_range = err_range_q;
  assign err_full  = err_full_q;

  // Session FSM plus write address, word count and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      err_range_q <= 1'b0;
      err_full_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            addr_q      <= base_addr;
            count_q     <= '0;
            err_range_q <= 1'b0;
            err_full_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (finish || err_full_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (occ_q == 3'd0) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept && !enc_legal) err_range_q <= 1'b1;

      if (pop) begin
        if (addr_q != 8'hFF) addr_q <= addr_q + 8'd1;
        else                 err_full_q <= 1'b1;
        if (count_q != 9'd256) count_q <= count_q + 9'd1;
      end
    end
  end

  // FIFO pointers and registered occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || session_start || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      occ_q <= occ_q + 3'(push) - 3'(pop);
    end
  end

  // FIFO word storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: an arithmetic model of the
// expected write stream is checked on every cycle, plus literal expectations.

module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, finish, in_valid, mem_ack;
  logic [7:0]  base_addr;
  logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [3:0]  in_funct;
  logic [15:0] in_imm;
  logic        in_ready, mem_we, busy, done, err_range, err_full;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  count;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct(in_funct), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .count(count), .err_range(err_range),
    .err_full(err_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the specification: queue of encoded words awaiting a write.
  int exp_q[$];
  int m_addr, m_count;
  bit m_err_range, m_err_full;
  bit m_legal, m_flushed;
  int m_data;
  int wlog_addr[$];
  int wlog_data[$];

  function automatic void model_enc(input int op, input int rd, input int rs1, input int rs2,
                                    input int funct, input int imm,
                                    output bit legal, output int data);
    legal = 1'b1;
    data  = 0;
    case (op)
      0, 1: data = op * 8192 + rd * 1024 + rs1 * 128 + rs2 * 16 + funct;
      2, 3, 4: begin
        legal = (imm >= -64) && (imm <= 63);
        data  = op * 8192 + rd * 1024 + rs1 * 128 + ((imm + 128) % 128);
      end
      5: begin
        legal = (imm >= -512) && (imm <= 511);
        data  = op * 8192 + rs1 * 1024 + ((imm + 1024) % 1024);
      end
      default: begin
        legal = (imm >= 0) && (imm <= 8191);
        data  = op * 8192 + imm;
      end
    endcase
  endfunction

  // Compare outputs with the model, then advance the model across the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mem_we", 32'(mem_we), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_q[0]));
      end
      check("count", 32'(count), 32'(m_count));
      check("err_range", 32'(err_range), 32'(m_err_range));
      check("err_full", 32'(err_full), 32'(m_err_full));
      if (mem_we && mem_ack) begin
        wlog_addr.push_back(int'(mem_addr));
        wlog_data.push_back(int'(mem_wdata));
      end
    end
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      m_addr = 0; m_count = 0; m_err_range = 0; m_err_full = 0;
    end else if (start && !busy && !done) begin
      exp_q.delete();
      m_addr = int'(base_addr); m_count = 0; m_err_range = 0; m_err_full = 0;
    end else begin
      m_flushed = 0;
      if (mem_ack && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (m_count < 256) m_count++;
        if (m_addr == 255) begin
          m_err_full = 1; exp_q.delete(); m_flushed = 1;
        end else begin
          m_addr++;
        end
      end
      if (in_valid && in_ready) begin
        model_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_funct),
                  int'($signed(in_imm)), m_legal, m_data);
        if (!m_legal) m_err_range = 1;
        else if (!m_flushed) exp_q.push_back(m_data);
      end
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input int funct, input int imm, input int limit, output bit ok);
    in_op = 3'(op); in_rd = 3'(rd); in_rs1 = 3'(rs1); in_rs2 = 3'(rs2);
    in_funct = 4'(funct); in_imm = 16'(imm); in_valid = 1'b1; ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ok(input int op, input int rd, input int rs1, input int rs2,
                         input int funct, input int imm);
    bit ok;
    send(op, rd, rs1, rs2, funct, imm, 50, ok);
    check("accepted", 32'(ok), 32'd1);
  endtask

  task automatic begin_session(input int b);
    start = 1'b1; base_addr = 8'(b);
    @(posedge clk); #1;
    start = 1'b0;
    wlog_addr.delete(); wlog_data.delete();
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("done_pulse_len", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_err_range"}, 32'(err_range), 32'd0);
    check({tag, "_err_full"}, 32'(err_full), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    base_addr = '0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic LI word, single write at the base address.
    mem_ack = 1'b1;
    begin_session(8'h10);
    send_ok(OP_LI, 2, 0, 0, 0, -1);
    pulse_finish();
    wait_done();
    check("li_nwrites", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() >= 1) begin
      check("li_addr", 32'(wlog_addr[0]), 32'h10);
      check("li_data", 32'(wlog_data[0]), 32'h487F);
    end
    check("li_count", 32'(count), 32'd1);

    // JAL at max target, then R-type accepted together with finish.
    begin_session(8'h20);
    send_ok(OP_JAL, 0, 0, 0, 0, 8191);
    finish = 1'b1;
    send_ok(OP_R_TYPE, 1, 2, 3, 5, 0);
    finish = 1'b0;
    wait_done();
    check("jal_r_nwrites", 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() >= 2) begin
      check("jal_data", 32'(wlog_data[0]), 32'hFFFF);
      check("rtype_data", 32'(wlog_data[1]), 32'h0535);
      check("rtype_addr", 32'(wlog_addr[1]), 32'h21);
    end

    // Back-pressure: four words queued, acknowledge withheld.
    mem_ack = 1'b0;
    begin_session(8'h40);
    send_ok(OP_SW, 3, 4, 0, 0, -5);
    send_ok(OP_LW, 1, 7, 0, 0, 63);
    send_ok(OP_SHIFT, 5, 6, 7, 9, 0);
    send_ok(OP_BNEZ, 0, 2, 0, 0, -3);
    start = 1'b1; base_addr = 8'h99;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_addr", 32'(mem_addr), 32'h40);
      check("bp_wdata", 32'(mem_wdata), 32'h8E7B);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    pulse_finish();
    wait_done();
    check("bp_nwrites", 32'(wlog_addr.size()), 32'd4);
    if (wlog_addr.size() >= 4) check("bp_last_addr", 32'(wlog_addr[3]), 32'h43);
    check("bp_count", 32'(count), 32'd4);

    // Out-of-range branch offset is dropped; next word takes its address.
    begin_session(8'h50);
    send_ok(OP_BNEZ, 0, 1, 0, 0, 600);
    @(negedge clk);
    check("range_flag", 32'(err_range), 32'd1);
    check("range_count", 32'(count), 32'd0);
    check("range_no_write", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    send_ok(OP_BNEZ, 0, 1, 0, 0, -2);
    pulse_finish();
    wait_done();
    check("range_nwrites", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() >= 1) begin
      check("range_next_addr", 32'(wlog_addr[0]), 32'h50);
      check("range_next_data", 32'(wlog_data[0]), 32'hA7FE);
    end

    // Address-space exhaustion near the top.
    begin_session(8'hFE);
    send_ok(OP_LI, 1, 0, 0, 0, 1);
    send_ok(OP_LI, 1, 0, 0, 0, 2);
    send_ok(OP_LI, 1, 0, 0, 0, 3);
    send(OP_LI, 1, 0, 0, 0, 4, 1, ok);
    check("full_blocks_input", 32'(ok), 32'd0);
    wait_done();
    check("full_nwrites", 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() >= 2) begin
      check("full_addr0", 32'(wlog_addr[0]), 32'hFE);
      check("full_addr1", 32'(wlog_addr[1]), 32'hFF);
    end
    check("full_flag", 32'(err_full), 32'd1);
    check("full_count", 32'(count), 32'd2);
    check("full_addr_nowrap", 32'(mem_addr), 32'hFF);

    // Reset while a write is pending.
    mem_ack = 1'b0;
    begin_session(8'h30);
    send_ok(OP_J, 0, 0, 0, 0, 100);
    @(negedge clk);
    check("pre_reset_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port start  input  1  begin a load session at base_addr; ignored unless IDLE.
REQ-004 SHALL have port base_addr  input  8  first instruction-memory word address, captured on start.
REQ-005 SHALL have port finish  input  1  end of program; drain and complete.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1  field-stream handshake; transfer when both high.
REQ-007 SHALL have ports in_op input 3 (definitions opcode), in_rd / in_rs1 / in_rs2 input 3 each, in_funct input 4, in_imm input 16 (signed).
REQ-008 SHALL have ports mem_we output 1, mem_addr output 8, mem_wdata output 16  instruction-memory write request.
REQ-009 SHALL have port mem_ack  input 1  memory accepted the current write.
REQ-010 SHALL have ports busy output 1, done output 1 (one-cycle pulse), count output 9 (words written this session).
REQ-011 SHALL have ports err_range output 1 (sticky immediate out of range) and err_full output 1 (sticky address space exhausted).

Function
REQ-012 SHALL encode opcode in wdata[15:13] using the definitions package values (OP_R_TYPE ... OP_JAL).
REQ-013 SHALL encode OP_R_TYPE/OP_SHIFT as [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] funct; in_imm ignored.
REQ-014 SHALL encode OP_LI/OP_LW/OP_SW as [12:10] rd, [9:7] rs1, [6:0] imm7; legal in_imm -64..63.
REQ-015 SHALL encode OP_BNEZ as [12:10] rs1, [9:0] off10; legal in_imm -512..511.
REQ-016 SHALL encode OP_J/OP_JAL as [12:0] target13; legal in_imm 0..8191 (treated as unsigned).
REQ-017 SHALL, on an accepted word with illegal immediate, discard it (no FIFO push, count unchanged) and set err_range.
REQ-018 SHALL buffer encoded words in a 4-entry FIFO; in_ready = (state==LOAD) && FIFO not full (registered occupancy, no same-cycle pop bypass) && !err_full.
REQ-019 SHALL use FSM IDLE -> LOAD on start; LOAD -> DRAIN on finish or err_full; DRAIN -> DONE when FIFO empty and no write pending; DONE -> IDLE after one cycle.
REQ-020 SHALL present the FIFO head as mem_we=1 with mem_addr/mem_wdata held stable until the cycle mem_ack=1 is sampled.
REQ-021 SHALL, on mem_ack, pop the FIFO, increment mem_addr and count; next write may assert the following cycle.
REQ-022 SHALL have latency 1: word accepted in cycle N into an empty FIFO with no pending write appears on mem_we in cycle N+1.
REQ-023 SHALL set err_full when the write to address 255 is acknowledged; mem_addr does not wrap; remaining FIFO entries are discarded.
REQ-024 SHALL cap count at 256 (one session cannot exceed the address space).
REQ-025 SHALL assert busy in LOAD and DRAIN; done high only in DONE.
REQ-026 SHALL treat finish while in_valid && in_ready as: accept that word, then enter DRAIN.
REQ-027 SHALL ignore mem_ack when mem_we=0, and start/finish outside IDLE/LOAD respectively.
REQ-028 SHALL clear err_range, err_full, count on start.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, enter IDLE, empty FIFO, and drive mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, count=0, err_range=0, err_full=0.
REQ-030 SHALL abandon any pending write on reset mid-session without an extra mem_we cycle.

Verification
REQ-031 start base_addr=0x10; OP_LI rd=2 rs1=0 imm=-1; finish; mem_ack each write -> mem_we addr 0x10 data {OP_LI,3'd2,3'd0,7'h7F}; count=1; done pulse.
REQ-032 mem_ack held low 5 cycles with 4 words queued -> in_ready=0, mem_addr/mem_wdata stable, no word lost after ack resumes.
REQ-033 OP_BNEZ imm=600 -> no write, err_range=1, count unchanged; subsequent legal word written at same address.
REQ-034 base_addr=0xFE, stream 4 words with acks -> writes at 0xFE, 0xFF only; err_full=1; DRAIN -> done; count=2.
REQ-035 rst_n=0 while mem_we=1 -> next cycle mem_we=0, IDLE, all outputs at reset values.
REQ-036 OP_JAL imm=8191 and OP_R_TYPE rd=1 rs1=2 rs2=3 funct=5 -> wdata {OP_JAL,13'h1FFF} then {OP_R_TYPE,3'd1,3'd2,3'd3,4'd5}.
